axi_mm2s_burst_reader: RTL and testbench



---
 rtl/axi_mm2s_burst_reader_if.sv | 52 +++++
 rtl/axi_mm2s_burst_reader.sv | 155 +++++++++++++++
 tb/tb_axi_mm2s_burst_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mm2s_burst_reader_if.sv
// AXI4 read-address/read-data channels plus the AXI-Stream output of the
// MM2S burst reader, bundled so the engine and its responders share one port.
interface axi_mm2s_burst_reader_if #(
    parameter int AXI_WIDTH      = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 6
) ();
    logic [AXI_ID_WIDTH-1:0]   m_axi_arid;
    logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]                m_axi_arlen;
    logic [2:0]                m_axi_arsize;
    logic [1:0]                m_axi_arburst;
    logic                      m_axi_arlock;
    logic [3:0]                m_axi_arcache;
    logic [2:0]                m_axi_arprot;
    logic                      m_axi_arvalid;
    logic                      m_axi_arready;

    logic [AXI_ID_WIDTH-1:0]   m_axi_rid;
    logic [AXI_WIDTH-1:0]      m_axi_rdata;
    logic [1:0]                m_axi_rresp;
    logic                      m_axi_rlast;
    logic                      m_axi_rvalid;
    logic                      m_axi_rready;

    logic [AXI_WIDTH-1:0]      m_axis_tdata;
    logic                      m_axis_tvalid;
    logic                      m_axis_tready;
    logic                      m_axis_tlast;

    // Read initiator / stream source side
    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    // Memory responder / stream sink side
    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
               m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/axi_mm2s_burst_reader.sv
// MM2S DMA read engine: fetches num_beats contiguous beats starting at
// base_addr with INCR bursts (one outstanding, never crossing 4 KB) and
// forwards them through a one-deep register onto an AXI-Stream port.
//
// state | meaning
// IDLE  | waiting for start
// ADDR  | presenting the next burst on AR, waiting for arready
// DATA  | accepting the beats of the current burst
// FIN   | draining the output register, then pulsing done
module axi_mm2s_burst_reader #(
    parameter int AXI_WIDTH         = 128,
    parameter int AXI_ADDR_WIDTH    = 32,
    parameter int AXI_ID_WIDTH      = 6,
    parameter int AXI_MAX_BURST_LEN = 32,
    parameter int AXI_ID            = 0
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [31:0]               num_beats,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    axi_mm2s_burst_reader_if.master   axi
);
    localparam int BB        = AXI_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BB);
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~(AXI_ADDR_WIDTH'(BB - 1));
    localparam logic [31:0] MAX_LEN = 32'(AXI_MAX_BURST_LEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    logic [1:0]                state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [31:0]               remaining;
    logic [8:0]                burst_cnt;

    logic [8:0]  rem_cap;
    logic [12:0] page_bytes;
    logic [12:0] page_beats;
    logic [8:0]  burst_len;
    logic        r_fire;
    logic        last_beat;
    logic        unused_inputs;

    // Burst length: remaining beats, capped by the burst limit and by the 4 KB page
    always_comb begin
        rem_cap    = (remaining > MAX_LEN) ? MAX_LEN[8:0] : remaining[8:0];
        page_bytes = 13'd4096 - {1'b0, addr[11:0]};
        page_beats = page_bytes >> SIZE_LOG2;
        burst_len  = ({4'd0, rem_cap} < page_beats) ? rem_cap : page_beats[8:0];
    end

    assign axi.m_axi_arid    = AXI_ID_WIDTH'(AXI_ID);
    assign axi.m_axi_araddr  = addr;
    assign axi.m_axi_arlen   = (state == ADDR) ? 8'(burst_len - 9'd1) : 8'd0;
    assign axi.m_axi_arsize  = 3'(SIZE_LOG2);
    assign axi.m_axi_arburst = 2'b01;
    assign axi.m_axi_arlock  = 1'b0;
    assign axi.m_axi_arcache = 4'b0011;
    assign axi.m_axi_arprot  = 3'b000;
    assign axi.m_axi_arvalid = (state == ADDR);

    // Accept a beat only when the output register is empty or being emptied
    assign axi.m_axi_rready = (state == DATA) && (!axi.m_axis_tvalid || axi.m_axis_tready);
    assign r_fire           = axi.m_axi_rready && axi.m_axi_rvalid;
    assign last_beat        = (remaining == 32'd0) && (burst_cnt == 9'd1);

    // rid is not checked and rlast is not trusted; bursts end on the local count
    assign unused_inputs = ^{axi.m_axi_rid, axi.m_axi_rlast};

    // Sequencing FSM with address/beat bookkeeping and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            burst_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        error <= 1'b0;
                        busy  <= 1'b1;
                        if (num_beats == 32'd0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            addr      <= base_addr & ALIGN_MASK;
                            remaining <= num_beats;
                            state     <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (axi.m_axi_arready) begin
                        addr      <= addr + (AXI_ADDR_WIDTH'(burst_len) << SIZE_LOG2);
                        remaining <= remaining - 32'(burst_len);
                        burst_cnt <= burst_len;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (r_fire) begin
                        burst_cnt <= burst_cnt - 9'd1;
                        if (axi.m_axi_rresp != 2'b00) begin
                            error <= 1'b1;
                        end
                        if (burst_cnt == 9'd1) begin
                            state <= (remaining != 32'd0) ? ADDR : FIN;
                        end
                    end
                end
                FIN: begin
                    // A zero-beat start already raised done on entry here
                    if (done) begin
                        state <= IDLE;
                    end else if (!axi.m_axis_tvalid ||
                                 (axi.m_axis_tready && axi.m_axis_tlast)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-deep stream output register; reload and drain may coincide
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            axi.m_axis_tdata  <= '0;
            axi.m_axis_tvalid <= 1'b0;
            axi.m_axis_tlast  <= 1'b0;
        end else if (r_fire) begin
            axi.m_axis_tdata  <= axi.m_axi_rdata;
            axi.m_axis_tvalid <= 1'b1;
            axi.m_axis_tlast  <= last_beat;
        end else if (axi.m_axis_tvalid && axi.m_axis_tready) begin
            axi.m_axis_tvalid <= 1'b0;
            axi.m_axis_tlast  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_mm2s_burst_reader.sv
// Bench for the MM2S burst reader: a RAM responder and stream sink with
// optional random stalls, and a reference model of the expected AR bursts
// and stream words derived from the transfer parameters.
module tb_axi_mm2s_burst_reader;
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] num_beats;
    logic        busy;
    logic        done;
    logic        error;

    axi_mm2s_burst_reader_if #(.AXI_WIDTH(128), .AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(6)) axi ();

    axi_mm2s_burst_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .base_addr (base_addr),
        .num_beats (num_beats),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .axi       (axi)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Transfer parameters, written by the stimulus block only
    logic [31:0] exp_base = 0;
    int          exp_n    = 0;
    int          err_beat = -1;
    bit          rnd_mode = 0;

    // Responder/monitor state, written by the monitor only
    ar_t         exp_ar[$];
    ar_t         r_q[$];
    int          ar_seen  = 0;
    int          s_idx    = 0;
    int          r_beat   = 0;
    int          r_idx    = 0;
    int          done_cnt = 0;
    bit          r_hold   = 0;
    bit          prev_ar_wait = 0;
    bit          prev_t_wait  = 0;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    logic [127:0] prev_tdata;
    logic        prev_tlast;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a, ~a, a + 32'h1234_5678};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM responder, stream sink and protocol monitor; inputs change on the
    // falling edge and the handshakes that the next rising edge will see are
    // evaluated just after
    always @(negedge clk) begin
        if (!rstn) begin
            axi.m_axi_arready = 1'b0;
            axi.m_axi_rvalid  = 1'b0;
            axi.m_axi_rlast   = 1'b0;
            axi.m_axi_rresp   = 2'b00;
            axi.m_axi_rdata   = '0;
            axi.m_axi_rid     = '0;
            axi.m_axis_tready = 1'b0;
            r_q.delete();
            r_idx = 0;
            r_hold = 0;
            prev_ar_wait = 0;
            prev_t_wait = 0;
        end else begin
            if (start) begin
                logic [31:0] a;
                int rem, page, l;
                exp_ar.delete();
                a = exp_base & ~32'hF;
                rem = exp_n;
                while (rem > 0) begin
                    page = (4096 - int'(a % 4096)) / 16;
                    l = rem;
                    if (l > 32) l = 32;
                    if (l > page) l = page;
                    exp_ar.push_back('{a, 8'(l - 1)});
                    a = a + 32'(l * 16);
                    rem = rem - l;
                end
                ar_seen = 0;
                s_idx = 0;
                r_beat = 0;
                done_cnt = 0;
            end
            if (prev_ar_wait) begin
                chk("arvalid_hold", axi.m_axi_arvalid, 1'b1);
                chk("araddr_hold", axi.m_axi_araddr, prev_araddr);
                chk("arlen_hold", axi.m_axi_arlen, prev_arlen);
            end
            if (prev_t_wait) begin
                chk("tvalid_hold", axi.m_axis_tvalid, 1'b1);
                chk("tdata_hold", axi.m_axis_tdata, prev_tdata);
                chk("tlast_hold", axi.m_axis_tlast, prev_tlast);
            end

            axi.m_axi_arready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!r_hold) begin
                axi.m_axi_rvalid = (r_q.size() > 0) && (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1);
            end
            if (axi.m_axi_rvalid) begin
                axi.m_axi_rdata = mem_word(r_q[0].addr + 32'(r_idx * 16));
                axi.m_axi_rlast = (r_idx == int'(r_q[0].len));
                axi.m_axi_rresp = (r_beat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                axi.m_axi_rlast = 1'b0;
                axi.m_axi_rresp = 2'b00;
            end
            axi.m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;

            #1;
            if (axi.m_axi_arvalid && axi.m_axi_arready) begin
                if (ar_seen < exp_ar.size()) begin
                    chk("araddr", axi.m_axi_araddr, exp_ar[ar_seen].addr);
                    chk("arlen", axi.m_axi_arlen, exp_ar[ar_seen].len);
                end else begin
                    chk("ar_extra", ar_seen, exp_ar.size() - 1);
                end
                chk("ar_fixed", {axi.m_axi_arid, axi.m_axi_arsize, axi.m_axi_arburst,
                                 axi.m_axi_arlock, axi.m_axi_arcache, axi.m_axi_arprot},
                                {6'd0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'd0});
                r_q.push_back('{axi.m_axi_araddr, axi.m_axi_arlen});
                ar_seen++;
            end
            prev_ar_wait = axi.m_axi_arvalid && !axi.m_axi_arready;
            prev_araddr  = axi.m_axi_araddr;
            prev_arlen   = axi.m_axi_arlen;

            if (axi.m_axi_rvalid && axi.m_axi_rready) begin
                r_beat++;
                r_hold = 0;
                if (r_idx == int'(r_q[0].len)) begin
                    void'(r_q.pop_front());
                    r_idx = 0;
                end else begin
                    r_idx++;
                end
            end else begin
                r_hold = axi.m_axi_rvalid;
            end

            if (axi.m_axis_tvalid && axi.m_axis_tready) begin
                if (s_idx < exp_n) begin
                    chk("tdata", axi.m_axis_tdata, mem_word((exp_base & ~32'hF) + 32'(s_idx * 16)));
                    chk("tlast", axi.m_axis_tlast, s_idx == exp_n - 1);
                end else begin
                    chk("t_extra", s_idx, exp_n - 1);
                end
                s_idx++;
            end
            prev_t_wait = axi.m_axis_tvalid && !axi.m_axis_tready;
            prev_tdata  = axi.m_axis_tdata;
            prev_tlast  = axi.m_axis_tlast;

            if (done) done_cnt++;
        end
    end

    task automatic pulse_start(input logic [31:0] base, input int n);
        @(negedge clk);
        #3;
        start = 1'b1;
        base_addr = base;
        num_beats = 32'(n);
    endtask

    task automatic run(input logic [31:0] base, input int n, input bit rnd, input int eb);
        exp_base = base;
        exp_n    = n;
        rnd_mode = rnd;
        err_beat = eb;
        pulse_start(base, n);
        @(negedge clk);
        #3;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("error_cleared", error, 1'b0);
        for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
            @(negedge clk);
            #2;
        end
        repeat (3) @(negedge clk);
        #2;
        chk("done_count", done_cnt, 1);
        chk("beats_streamed", s_idx, n);
        chk("bursts_issued", ar_seen, exp_ar.size());
        chk("busy_end", busy, 1'b0);
        chk("error_end", error, (eb >= 0 && eb < n));
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_beats = '0;
        #1;
        chk("reset_outputs", {busy, done, error, axi.m_axi_arvalid, axi.m_axi_rready,
                              axi.m_axis_tvalid, axi.m_axis_tlast, axi.m_axi_arlen},
                             '0);
        chk("reset_araddr", axi.m_axi_araddr, 32'd0);
        chk("reset_tdata", axi.m_axis_tdata, 128'd0);
        repeat (3) @(negedge clk);
        #3;
        rstn = 1'b1;

        run(32'h1000, 8, 0, -1);
        run(32'h0000, 100, 0, -1);
        run(32'h0FC0, 10, 0, -1);
        run(32'h2000, 64, 1, -1);
        run(32'h3000, 3, 0, 1);
        run(32'h3100, 4, 1, -1);
        for (int k = 0; k < 4; k++) begin
            run(32'($urandom_range(0, 32'hFFFF)), int'($urandom_range(1, 70)), 1,
                (k == 2) ? int'($urandom_range(0, 5)) : -1);
        end

        // Zero-beat transfer: done on the cycle after start, no AR
        exp_base = 32'h7000;
        exp_n = 0;
        err_beat = -1;
        rnd_mode = 0;
        pulse_start(32'h7000, 0);
        @(negedge clk);
        #2;
        chk("zero_done", done, 1'b1);
        chk("zero_busy", busy, 1'b1);
        chk("zero_arvalid", axi.m_axi_arvalid, 1'b0);
        #1;
        start = 1'b0;
        @(negedge clk);
        #2;
        chk("zero_done_gone", done, 1'b0);
        chk("zero_busy_gone", busy, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        chk("zero_no_ar", ar_seen, 0);
        chk("zero_done_count", done_cnt, 1);

        // Reset in the middle of a transfer
        exp_base = 32'h5000;
        exp_n = 40;
        rnd_mode = 1;
        pulse_start(32'h5000, 40);
        @(negedge clk);
        #3;
        start = 1'b0;
        for (int c = 0; c < 3000 && s_idx < 5; c++) begin
            @(negedge clk);
            #2;
        end
        chk("midreset_progress", s_idx >= 5, 1'b1);
        @(negedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, error, axi.m_axi_arvalid, axi.m_axi_rready,
                                 axi.m_axis_tvalid, axi.m_axis_tlast, axi.m_axi_arlen},
                                '0);
        chk("midreset_araddr", axi.m_axi_araddr, 32'd0);
        chk("midreset_tdata", axi.m_axis_tdata, 128'd0);
        repeat (2) @(negedge clk);
        #3;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        chk("midreset_no_done", done_cnt, 0);
        chk("midreset_idle", {busy, axi.m_axi_arvalid}, 2'b00);
        run(32'h6000, 20, 1, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
